// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
// Holds op encodings, flag bit positions and the controller state enum.
// ALU_MUL_EN selects whether the BUSY state (iterative multiply) exists.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ERR   = 4;
    localparam int FLAG_COUNT = 5;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } alu_state_t;
`endif

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
// The final partial sum is presented combinationally alongside done so the
// caller can register the product on the WIDTH-th edge after start.
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] addend;

    // Next partial sum; on the last step this is the full product
    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        product = acc + addend;
        done    = (count == CW'(1));
    end

    // Load operands on start, then consume one multiplier bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= CW'(WIDTH);
        end else if (count != '0) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on both sides and status flags.
// Single-cycle ops register their result on the accept edge; MUL runs through
// alu_mul_seq when ALU_MUL_EN is defined, otherwise it reports err=1.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [2:0]            op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic [FLAG_COUNT-1:0] flags
);

    localparam int MSB = WIDTH - 1;

    alu_state_t state;

    logic                  accept;
    logic [WIDTH:0]        sum_w;
    logic [WIDTH:0]        diff_w;
    logic [WIDTH:0]        shl_w;
    logic [WIDTH:0]        shr_w;
    logic                  big_shift;
    logic                  alu_carry;
    logic                  alu_ovf;
    logic                  alu_err;
    logic [WIDTH-1:0]      alu_result;
    logic [FLAG_COUNT-1:0] alu_flags;

    // Handshake: accept when idle, or when the held result leaves this edge
    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Single-cycle datapath evaluated straight from the presented operands
    always_comb begin
        sum_w      = {1'b0, a} + {1'b0, b};
        diff_w     = {1'b0, a} - {1'b0, b};
        shl_w      = {1'b0, a} << b;
        shr_w      = {a, 1'b0} >> b;
        big_shift  = (b >= WIDTH'(WIDTH));
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        alu_err    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_result = sum_w[MSB:0];
                alu_carry  = sum_w[WIDTH];
                alu_ovf    = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_result = diff_w[MSB:0];
                alu_carry  = diff_w[WIDTH];
                alu_ovf    = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
            end
            OP_AND: alu_result = a & b;
            OP_OR:  alu_result = a | b;
            OP_XOR: alu_result = a ^ b;
            OP_SHL: begin
                if (b == '0) begin
                    alu_result = a;
                end else if (!big_shift) begin
                    alu_result = shl_w[MSB:0];
                    alu_carry  = shl_w[WIDTH];
                end
            end
            OP_SHR: begin
                if (b == '0) begin
                    alu_result = a;
                end else if (!big_shift) begin
                    alu_result = shr_w[WIDTH:1];
                    alu_carry  = shr_w[0];
                end
            end
            default: begin
`ifndef ALU_MUL_EN
                alu_err = 1'b1;
`endif
            end
        endcase
        alu_flags             = '0;
        alu_flags[FLAG_ZERO]  = (alu_result == '0);
        alu_flags[FLAG_CARRY] = alu_carry;
        alu_flags[FLAG_OVF]   = alu_ovf;
        alu_flags[FLAG_NEG]   = alu_result[MSB];
        alu_flags[FLAG_ERR]   = alu_err;
    end

`ifdef ALU_MUL_EN
    logic                  mul_start;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_product;
    logic [FLAG_COUNT-1:0] mul_flags;
    logic                  mul_high;

    // Multiplier launch and flag derivation from the final product
    always_comb begin
        mul_start             = accept && (op == OP_MUL);
        mul_high              = (mul_product[2*WIDTH-1:WIDTH] != '0);
        mul_flags             = '0;
        mul_flags[FLAG_ZERO]  = (mul_product[MSB:0] == '0);
        mul_flags[FLAG_CARRY] = mul_high;
        mul_flags[FLAG_OVF]   = mul_high;
        mul_flags[FLAG_NEG]   = mul_product[MSB];
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Controller: state, registered result/flags and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (accept) begin
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
                state     <= BUSY;
                out_valid <= 1'b0;
            end else
`endif
            begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= alu_result;
                flags     <= alu_flags;
            end
        end else begin
            case (state)
`ifdef ALU_MUL_EN
                BUSY: begin
                    if (mul_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= mul_product[MSB:0];
                        flags     <= mul_flags;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq at WIDTH=4 against a
// plain-arithmetic reference model. Honours ALU_MUL_EN like the design does.
module tb_alu_seq;

    localparam int W = 4;
`ifdef ALU_MUL_EN
    localparam int MUL_LAT = W;
`else
    localparam int MUL_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [4:0]   flags;

    int tests_run = 0;
    int tests_failed = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Reference model from the arithmetic rules; flags = {err,neg,ovf,carry,zero}
    function automatic void model(input int av, input int bv, input int opv,
                                  output logic [W-1:0] r_out, output logic [4:0] f_out);
        int m;
        int half;
        int sa;
        int sb;
        int full;
        int r;
        bit c;
        bit o;
        bit e;
        m = 1 << W;
        half = m / 2;
        sa = (av >= half) ? av - m : av;
        sb = (bv >= half) ? bv - m : bv;
        r = 0; c = 0; o = 0; e = 0;
        case (opv)
            0: begin full = av + bv; r = full % m; c = (full >= m);
                     o = ((sa + sb) >= half) || ((sa + sb) < -half); end
            1: begin r = (av - bv + m) % m; c = (av < bv);
                     o = ((sa - sb) >= half) || ((sa - sb) < -half); end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: begin
                if (bv == 0) r = av;
                else if (bv >= W) r = 0;
                else begin r = (av << bv) % m; c = ((av >> (W - bv)) & 1) != 0; end
            end
            6: begin
                if (bv == 0) r = av;
                else if (bv >= W) r = 0;
                else begin r = av >> bv; c = ((av >> (bv - 1)) & 1) != 0; end
            end
            default: begin
`ifdef ALU_MUL_EN
                full = av * bv; r = full % m; c = (full >= m); o = c;
`else
                e = 1; r = 0;
`endif
            end
        endcase
        r_out = r[W-1:0];
        f_out = {e, (r >= half), o, c, (r == 0)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        tests_run++;
        if (result !== '0 || flags !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: result=%h flags=%b, want 0 00000", result, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
        end
    endtask

    // Directed single-cycle vectors: {a, b, op, result, flags}
    task automatic test_directed();
        logic [19:0] vec [12];
        logic [W-1:0] er;
        logic [4:0] ef;
        vec = '{
            {4'h3, 4'h1, 3'd0, 4'h4, 5'b00000},
            {4'hF, 4'h1, 3'd0, 4'h0, 5'b00011},
            {4'h7, 4'h1, 3'd0, 4'h8, 5'b01100},
            {4'h4, 4'h1, 3'd1, 4'h3, 5'b00000},
            {4'h1, 4'h2, 3'd1, 4'hF, 5'b01010},
            {4'hC, 4'hA, 3'd2, 4'h8, 5'b01000},
            {4'hC, 4'hA, 3'd3, 4'hE, 5'b01000},
            {4'hC, 4'hA, 3'd4, 4'h6, 5'b00000},
            {4'h3, 4'h2, 3'd5, 4'hC, 5'b01000},
            {4'h5, 4'h1, 3'd6, 4'h2, 5'b00010},
            {4'h3, 4'h4, 3'd5, 4'h0, 5'b00001},
            {4'h9, 4'h0, 3'd6, 4'h9, 5'b01000}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a = vec[i][19:16]; b = vec[i][15:12]; op = vec[i][11:9]; in_valid = 1'b1;
            er = vec[i][8:5]; ef = vec[i][4:0];
            @(posedge clk); #1;
            in_valid = 1'b0;
            tests_run++;
            if (out_valid !== 1'b1 || result !== er || flags !== ef) begin
                tests_failed++;
                $display("[TB] FAIL directed[%0d]: valid=%b result=%h flags=%b, want 1 %h %b",
                         i, out_valid, result, flags, er, ef);
            end
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL directed_drain[%0d]: out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_mul();
        @(negedge clk);
        a = 4'h3; b = 4'h5; op = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef ALU_MUL_EN
        for (int c = 1; c <= W; c++) begin
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL mul_busy[%0d]: out_valid=%b in_ready=%b, want 0 0", c, out_valid, in_ready);
            end
            if (c == 2) a = 4'hE;
            @(posedge clk); #1;
        end
        tests_run++;
        if (out_valid !== 1'b1 || result !== 4'hF || flags !== 5'b01000) begin
            tests_failed++;
            $display("[TB] FAIL mul_3x5: valid=%b result=%h flags=%b, want 1 f 01000", out_valid, result, flags);
        end
        @(negedge clk);
        a = 4'h5; b = 4'h5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || result !== 4'h9 || flags !== 5'b01110) begin
            tests_failed++;
            $display("[TB] FAIL mul_5x5: valid=%b result=%h flags=%b, want 1 9 01110", out_valid, result, flags);
        end
`else
        tests_run++;
        if (out_valid !== 1'b1 || result !== 4'h0 || flags !== 5'b10001) begin
            tests_failed++;
            $display("[TB] FAIL mul_disabled: valid=%b result=%h flags=%b, want 1 0 10001", out_valid, result, flags);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] er;
        logic [4:0] ef;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = W'($urandom_range(0, (1 << W) - 1));
            b = W'($urandom_range(0, (1 << W) - 1));
            op = 3'($urandom_range(0, 7));
            in_valid = 1'b1;
            model(int'(a), int'(b), int'(op), er, ef);
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = ~a;
            lat = 0;
            while (out_valid !== 1'b1 && lat < W + 4) begin
                @(posedge clk); #1;
                lat++;
            end
            tests_run++;
            if (out_valid !== 1'b1 || result !== er || flags !== ef ||
                lat != ((op == 3'd7) ? MUL_LAT : 0)) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d] op=%0d: valid=%b result=%h flags=%b lat=%0d, want 1 %h %b",
                         i, op, out_valid, result, flags, lat, er, ef);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] er;
        logic [4:0] ef;
        @(negedge clk);
        out_ready = 1'b0;
        a = 4'h9; b = 4'h9; op = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 4'h1; b = 4'h1; op = 3'd2;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 4'h2 || flags !== 5'b00110) begin
                tests_failed++;
                $display("[TB] FAIL hold[%0d]: valid=%b in_ready=%b result=%h flags=%b, want 1 0 2 00110",
                         c, out_valid, in_ready, result, flags);
            end
        end
        @(negedge clk);
        a = 4'h1; b = 4'h2; op = 3'd0; out_ready = 1'b1;
        model(1, 2, 0, er, ef);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || result !== er || flags !== ef) begin
            tests_failed++;
            $display("[TB] FAIL done_accept: valid=%b result=%h flags=%b, want 1 %h %b", out_valid, result, flags, er, ef);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er;
        logic [4:0] ef;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL b2b_ready[%0d]: in_ready=%b, want 1", i, in_ready);
            end
            a = W'($urandom_range(0, (1 << W) - 1));
            b = W'($urandom_range(0, (1 << W) - 1));
            op = 3'($urandom_range(0, 6));
            in_valid = 1'b1;
            model(int'(a), int'(b), int'(op), er, ef);
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || result !== er || flags !== ef) begin
                tests_failed++;
                $display("[TB] FAIL b2b[%0d]: valid=%b result=%h flags=%b, want 1 %h %b", i, out_valid, result, flags, er, ef);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        // Reset while a result is held in DONE
        @(negedge clk);
        out_ready = 1'b0;
        a = 4'h7; b = 4'h1; op = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || result !== '0 || flags !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_done: valid=%b result=%h flags=%b, want 0 0 00000", out_valid, result, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        // Reset while a multiply is in flight
        @(negedge clk);
        a = 4'h7; b = 4'h7; op = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || flags !== '0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_op: valid=%b flags=%b in_ready=%b, want 0 00000 1", out_valid, flags, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < W + 2; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_no_emit[%0d]: out_valid=%b, want 0", c, out_valid);
            end
        end
        @(negedge clk);
        a = 4'h2; b = 4'h2; op = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || result !== 4'h4 || flags !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_add: valid=%b result=%h flags=%b, want 1 4 00000", out_valid, result, flags);
        end
        @(posedge clk); #1;
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with valid/ready handshakes on input and output, status flags and an optional iterative multiply. It generalises the team's 4-bit combinational ALU: operand width is a parameter, results are registered, and a multi-cycle op and flag generation are added. It sits between an operand-issue stage and a result-consumer stage. One operation is in flight at a time.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept; transfer when in_valid & in_ready at a clk edge
- a, b  in  WIDTH  operands, unsigned (two's complement for ovf/neg)
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready
- result  out  WIDTH  registered result
- flags  out  5  {err, neg, ovf, carry, zero}, registered with result

## Operation
- States: IDLE, BUSY (MUL only), DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational.
- Accept latches a, b, op. Input changes after accept have no effect.
- Single-cycle ops go from accept to DONE.
- MUL goes from accept to BUSY. Shift-add, one bit of b per cycle, WIDTH cycles, then DONE.
- DONE: out_valid=1; result/flags held stable until the output transfer.
- On output transfer: accept the new input in the same edge if in_valid, else return to IDLE.
- ADD: carry = carry-out; ovf = signed overflow.
- SUB: a−b mod 2^WIDTH; carry = borrow (a<b unsigned); ovf = signed overflow.
- AND/OR/XOR: carry=0, ovf=0.
- SHL/SHR: shamt = b as unsigned.
  - shamt=0: result=a, carry=0.
  - shamt≥WIDTH: result=0, carry=0.
  - Otherwise carry = last bit shifted out.
  - ovf=0.
- MUL: result = low WIDTH bits of a*b; carry = ovf = (high WIDTH bits ≠ 0).
- All ops: zero = (result==0); neg = result[WIDTH-1]; err=0 except as in Configuration.

## Timing
- Reset: state IDLE, out_valid 0, result 0, flags 0. in_ready reads 1 during and after reset.
- Single-cycle ops: accept at edge k → out_valid=1 after edge k+1.
- MUL: accept at edge k → out_valid=1 after edge k+WIDTH.
- in_ready=0 throughout BUSY.
- Back-to-back throughput: one op per cycle for single-cycle ops while out_ready=1.
- Reset asserted mid-BUSY or in DONE: in-flight op discarded, outputs to reset values immediately (asynchronous). No result is emitted for it.
- out_ready high while out_valid=0 has no effect.

## Configuration
- ALU_MUL_EN defined:
  - MUL implemented as above.
  - BUSY state and multiplier present.
- ALU_MUL_EN undefined:
  - op 111 takes the single-cycle path: result=0, err=1, zero=1, other flags 0.
  - No BUSY state or multiplier logic.

## Structure
- Package alu_pkg holds:
  - op encodings
  - flag bit indices (ZERO=0, CARRY=1, OVF=2, NEG=3, ERR=4)
  - state enum
- Sub-module alu_mul_seq: iterative shift-add multiplier with start/done, WIDTH parameter. Instantiated only under ALU_MUL_EN.

## Test plan
- WIDTH=4, single-cycle ops:
  - ADD 3+1 → result 4, flags 00000, out_valid one cycle after accept.
  - ADD F+1 → 0, zero=1, carry=1.
  - ADD 7+1 → 8, ovf=1, neg=1.
- SUB:
  - 4−1 → 3, carry=0.
  - 1−2 → F, carry=1, neg=1, ovf=0.
- Logic ops on C, A: AND → 8, OR → E, XOR → 6.
- Shifts:
  - SHL 3 by 2 → C, carry=0.
  - SHR 5 by 1 → 2, carry=1.
  - SHL by 4 → 0, zero=1.
- MUL (ALU_MUL_EN):
  - 3*5 → F, carry=0, out_valid after exactly 4 cycles.
  - 5*5 → 9, carry=ovf=1.
  - in_ready=0 during BUSY; a changed mid-op ignored.
  - Without ALU_MUL_EN: err=1, result 0, 1-cycle latency.
- Handshake:
  - out_ready low 3 cycles → result/flags stable, in_ready=0.
  - out_ready high in DONE with in_valid → new op accepted same edge, next result one cycle later.
- Reset: rst_n low mid-MUL → out_valid=0 and flags=0 immediately. After release, in_ready=1 and the next ADD 2+2 → 4.
